// File: rtl/fetch_bp_pkg.sv
// rtl/fetch_bp_pkg.sv - shared BTB entry type, counter encodings and counter helper
// Used by fetch_bp and fetch_bp_btb; the BTB itself is built only with FETCH_BP_BTB_EN.
package fetch_bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

  // Fields sized for the widest supported XLEN; narrower builds zero-extend into them.
  localparam int BTB_FIELD_W = 64;

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
    ctr_t                   ctr;
  } btb_entry_t;

  localparam btb_entry_t BTB_ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};

  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    if (taken) begin
      return (ctr == ST) ? ST : ctr + 2'd1;
    end
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/fetch_bp_btb.sv
// rtl/fetch_bp_btb.sv - direct-mapped branch target buffer with 2-bit counters
// Combinational lookup from the fetch PC; updates land on the clock edge.
module fetch_bp_btb
  import fetch_bp_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] i_lookup_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [XLEN-1:0] i_upd_target
);

  localparam int IDX   = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX - 2;

  btb_entry_t r_btb [BTB_DEPTH];

  logic [IDX-1:0]   w_lk_idx;
  logic [IDX-1:0]   w_up_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [TAG_W-1:0] w_up_tag;
  btb_entry_t       w_lk_entry;
  btb_entry_t       w_up_entry;
  btb_entry_t       w_up_next;
  logic             w_lk_hit;
  logic             w_up_hit;
  logic             w_up_write;
  logic [1:0]       w_unused_lo;

  assign w_lk_idx    = i_lookup_pc[IDX+1:2];
  assign w_lk_tag    = i_lookup_pc[XLEN-1:IDX+2];
  assign w_up_idx    = i_upd_pc[IDX+1:2];
  assign w_up_tag    = i_upd_pc[XLEN-1:IDX+2];
  // Instruction-aligned PCs: the byte offset never participates in index or tag.
  assign w_unused_lo = i_lookup_pc[1:0] ^ i_upd_pc[1:0];

  assign w_lk_entry    = r_btb[w_lk_idx];
  assign w_lk_hit      = w_lk_entry.valid && (w_lk_entry.tag == BTB_FIELD_W'(w_lk_tag));
  assign o_pred_taken  = w_lk_hit && w_lk_entry.ctr[1];
  assign o_pred_target = o_pred_taken ? XLEN'(w_lk_entry.target) : '0;

  assign w_up_entry = r_btb[w_up_idx];
  assign w_up_hit   = w_up_entry.valid && (w_up_entry.tag == BTB_FIELD_W'(w_up_tag));

  always_comb begin
    w_up_next  = w_up_entry;
    w_up_write = 1'b0;
    if (i_upd_valid) begin
      if (w_up_hit) begin
        w_up_write    = 1'b1;
        w_up_next.ctr = ctr_next(w_up_entry.ctr, i_upd_taken);
        if (i_upd_taken) begin
          w_up_next.target = BTB_FIELD_W'(i_upd_target);
        end
      end else if (i_upd_taken) begin
        // Miss and taken: evict whatever aliases here, start weakly taken.
        w_up_write = 1'b1;
        w_up_next  = '{valid:  1'b1,
                       tag:    BTB_FIELD_W'(w_up_tag),
                       target: BTB_FIELD_W'(i_upd_target),
                       ctr:    WT};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_btb[i] <= BTB_ENTRY_RESET;
      end
    end else if (w_up_write) begin
      r_btb[w_up_idx] <= w_up_next;
    end
  end

endmodule

// File: rtl/fetch_bp.sv
// rtl/fetch_bp.sv - fetch PC register and next-PC selection with optional BTB prediction
// Define FETCH_BP_BTB_EN to build the BTB; otherwise next PC is redirect/stall/pc+4 only.
module fetch_bp
  import fetch_bp_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  output logic [XLEN-1:0] imem_addr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_next;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;

  assign w_pc_plus4 = r_pc + XLEN'(4);

`ifdef FETCH_BP_BTB_EN
  fetch_bp_btb #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_lookup_pc   (r_pc),
    .o_pred_taken  (w_pred_taken),
    .o_pred_target (w_pred_target),
    .i_upd_valid   (upd_valid_i),
    .i_upd_pc      (upd_pc_i),
    .i_upd_taken   (upd_taken_i),
    .i_upd_target  (upd_target_i)
  );
`else
  logic w_unused_upd;

  assign w_pred_taken  = 1'b0;
  assign w_pred_target = '0;
  assign w_unused_upd  = ^{upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i};
`endif

  // Redirect beats stall: a correction must land even while fetch is held.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (redirect_i) begin
      w_pc_next = redirect_pc_i;
    end else if (stall_i) begin
      w_pc_next = r_pc;
    end else if (w_pred_taken) begin
      w_pc_next = w_pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign pc_o          = r_pc;
  assign imem_addr_o   = r_pc;
  assign pc_plus4_o    = w_pc_plus4;
  assign pred_taken_o  = w_pred_taken;
  assign pred_target_o = w_pred_target;

endmodule

// File: tb/tb_fetch_bp.sv
// tb/tb_fetch_bp.sv - scoreboard bench for fetch_bp (follows FETCH_BP_BTB_EN if defined)
module tb_fetch_bp;

`ifdef FETCH_BP_BTB_EN
  localparam bit BTB_EN = 1'b1;
`else
  localparam bit BTB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic [31:0] imem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg;
  } exp_t;

  typedef struct {
    bit          rd;
    logic [31:0] rpc;
    bit          st;
    bit          uv;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utg;
  } stim_t;

  exp_t exp_q[$];

  bit          m_v   [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_tgt [16];
  logic [1:0]  m_ctr [16];
  logic [31:0] m_pc;

  fetch_bp #(
    .XLEN      (32),
    .BTB_DEPTH (16),
    .RESET_PC  (32'h100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i),
    .imem_addr_o   (imem_addr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic stim_t S(input bit rd, input logic [31:0] rpc, input bit st,
                              input bit uv, input logic [31:0] upc, input bit ut,
                              input logic [31:0] utg);
    stim_t s;
    s.rd = rd; s.rpc = rpc; s.st = st; s.uv = uv; s.upc = upc; s.ut = ut; s.utg = utg;
    return s;
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    int i = int'(pc[5:2]);
    return BTB_EN && m_v[i] && (m_tag[i] == pc[31:6]) && (m_ctr[i] >= 2'd2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[int'(pc[5:2])] : 32'h0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 2'd1;
    end
    m_pc = 32'h100;
  endtask

  task automatic m_update(input logic [31:0] upc, input bit ut, input logic [31:0] utg);
    int i = int'(upc[5:2]);
    if (m_v[i] && m_tag[i] == upc[31:6]) begin
      if (ut) begin
        if (m_ctr[i] != 2'd3) m_ctr[i] = m_ctr[i] + 2'd1;
        m_tgt[i] = utg;
      end else if (m_ctr[i] != 2'd0) begin
        m_ctr[i] = m_ctr[i] - 2'd1;
      end
    end else if (ut) begin
      m_v[i] = 1'b1; m_tag[i] = upc[31:6]; m_tgt[i] = utg; m_ctr[i] = 2'd2;
    end
  endtask

  // Drives one cycle from a negedge, queues what the DUT must show after the edge.
  task automatic drive(input stim_t s);
    exp_t e;
    logic [31:0] nxt;
    redirect_i = s.rd; redirect_pc_i = s.rpc; stall_i = s.st;
    upd_valid_i = s.uv; upd_pc_i = s.upc; upd_taken_i = s.ut; upd_target_i = s.utg;
    if (s.rd) nxt = s.rpc;
    else if (s.st) nxt = m_pc;
    else if (m_taken(m_pc)) nxt = m_target(m_pc);
    else nxt = m_pc + 32'd4;
    if (s.uv) m_update(s.upc, s.ut, s.utg);
    m_pc = nxt;
    e.pc = nxt; e.pt = m_taken(nxt); e.ptg = m_target(nxt);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t t[$];
    exp_t  e;
    upd_valid_i = 1'b1; upd_pc_i = 32'h100; upd_taken_i = 1'b1; upd_target_i = 32'h700;
    repeat (2) @(negedge clk);
    total++;
    if ({pc_o, pred_taken_o, pred_target_o} !== {32'h100, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_state got pc=%h pt=%b tgt=%h need pc=00000100 pt=0 tgt=00000000",
               pc_o, pred_taken_o, pred_target_o);
    end
    upd_valid_i = 1'b0;
    rst_n = 1'b1;
    m_reset();
    t = '{S(0, 0, 0, 0, 0, 0, 0), S(0, 0, 0, 0, 0, 0, 0)};
    foreach (t[k]) begin
      drive(t[k]);
      e = exp_q.pop_front();
      total++;
      if ({pc_o, imem_addr_o, pc_plus4_o, pred_taken_o, pred_target_o} !==
          {e.pc, e.pc, e.pc + 32'd4, e.pt, e.ptg}) begin
        bad++;
        $display("FAIL reset_seq[%0d] got pc=%h imem=%h p4=%h pt=%b tgt=%h need pc=%h pt=%b tgt=%h",
                 k, pc_o, imem_addr_o, pc_plus4_o, pred_taken_o, pred_target_o, e.pc, e.pt, e.ptg);
      end
    end
  endtask

  task automatic test_alloc();
    stim_t t[$];
    exp_t  e;
    t = '{S(0, 0, 0, 1, 32'h108, 1, 32'h200),
          S(1, 32'h108, 0, 0, 0, 0, 0),
          S(0, 0, 0, 0, 0, 0, 0)};
    foreach (t[k]) begin
      drive(t[k]);
      e = exp_q.pop_front();
      total++;
      if ({pc_o, imem_addr_o, pc_plus4_o, pred_taken_o, pred_target_o} !==
          {e.pc, e.pc, e.pc + 32'd4, e.pt, e.ptg}) begin
        bad++;
        $display("FAIL alloc[%0d] got pc=%h imem=%h p4=%h pt=%b tgt=%h need pc=%h pt=%b tgt=%h",
                 k, pc_o, imem_addr_o, pc_plus4_o, pred_taken_o, pred_target_o, e.pc, e.pt, e.ptg);
      end
    end
  endtask

  task automatic test_saturation();
    stim_t t[$];
    exp_t  e;
    t = '{S(1, 32'h108, 0, 1, 32'h108, 0, 0),
          S(0, 0, 1, 1, 32'h108, 0, 0),
          S(0, 0, 1, 1, 32'h108, 0, 0),
          S(0, 0, 1, 1, 32'h108, 1, 32'h200),
          S(0, 0, 1, 1, 32'h108, 1, 32'h200),
          S(0, 0, 1, 1, 32'h108, 1, 32'h200),
          S(0, 0, 1, 1, 32'h108, 1, 32'h200),
          S(0, 0, 1, 1, 32'h108, 0, 0)};
    foreach (t[k]) begin
      drive(t[k]);
      e = exp_q.pop_front();
      total++;
      if ({pc_o, pred_taken_o, pred_target_o} !== {e.pc, e.pt, e.ptg}) begin
        bad++;
        $display("FAIL saturation[%0d] got pc=%h pt=%b tgt=%h need pc=%h pt=%b tgt=%h",
                 k, pc_o, pred_taken_o, pred_target_o, e.pc, e.pt, e.ptg);
      end
    end
  endtask

  task automatic test_priority();
    stim_t t[$];
    exp_t  e;
    t = '{S(1, 32'h400, 1, 0, 0, 0, 0),
          S(1, 32'h108, 0, 0, 0, 0, 0),
          S(0, 0, 1, 0, 0, 0, 0),
          S(0, 0, 0, 0, 0, 0, 0)};
    foreach (t[k]) begin
      drive(t[k]);
      e = exp_q.pop_front();
      total++;
      if ({pc_o, pred_taken_o, pred_target_o} !== {e.pc, e.pt, e.ptg}) begin
        bad++;
        $display("FAIL priority[%0d] got pc=%h pt=%b tgt=%h need pc=%h pt=%b tgt=%h",
                 k, pc_o, pred_taken_o, pred_target_o, e.pc, e.pt, e.ptg);
      end
    end
  endtask

  task automatic test_alias();
    stim_t t[$];
    exp_t  e;
    t = '{S(1, 32'h148, 0, 0, 0, 0, 0),
          S(0, 0, 0, 1, 32'h14B, 1, 32'h300),
          S(1, 32'h108, 0, 0, 0, 0, 0),
          S(0, 0, 0, 0, 0, 0, 0),
          S(1, 32'h148, 0, 0, 0, 0, 0),
          S(0, 0, 0, 0, 0, 0, 0)};
    foreach (t[k]) begin
      drive(t[k]);
      e = exp_q.pop_front();
      total++;
      if ({pc_o, pred_taken_o, pred_target_o} !== {e.pc, e.pt, e.ptg}) begin
        bad++;
        $display("FAIL alias[%0d] got pc=%h pt=%b tgt=%h need pc=%h pt=%b tgt=%h",
                 k, pc_o, pred_taken_o, pred_target_o, e.pc, e.pt, e.ptg);
      end
    end
  endtask

  task automatic test_wrap_same_cycle();
    stim_t t[$];
    exp_t  e;
    t = '{S(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0),
          S(0, 0, 0, 0, 0, 0, 0),
          S(1, 32'h148, 0, 0, 0, 0, 0),
          S(0, 0, 0, 1, 32'h148, 0, 0),
          S(1, 32'h148, 0, 0, 0, 0, 0),
          S(0, 0, 0, 0, 0, 0, 0)};
    foreach (t[k]) begin
      drive(t[k]);
      e = exp_q.pop_front();
      total++;
      if ({pc_o, imem_addr_o, pc_plus4_o, pred_taken_o, pred_target_o} !==
          {e.pc, e.pc, e.pc + 32'd4, e.pt, e.ptg}) begin
        bad++;
        $display("FAIL wrap[%0d] got pc=%h imem=%h p4=%h pt=%b tgt=%h need pc=%h pt=%b tgt=%h",
                 k, pc_o, imem_addr_o, pc_plus4_o, pred_taken_o, pred_target_o, e.pc, e.pt, e.ptg);
      end
    end
  endtask

  task automatic test_mid_reset();
    stim_t t[$];
    exp_t  e;
    drive(S(0, 0, 0, 1, 32'h148, 1, 32'h300));
    e = exp_q.pop_front();
    total++;
    if ({pc_o, pred_taken_o} !== {e.pc, e.pt}) begin
      bad++;
      $display("FAIL midreset_pre got pc=%h pt=%b need pc=%h pt=%b", pc_o, pred_taken_o, e.pc, e.pt);
    end
    upd_valid_i = 1'b1; upd_pc_i = 32'h108; upd_taken_i = 1'b1; upd_target_i = 32'h500;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({pc_o, pred_taken_o, pred_target_o} !== {32'h100, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL midreset_async got pc=%h pt=%b tgt=%h need pc=00000100 pt=0 tgt=00000000",
               pc_o, pred_taken_o, pred_target_o);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({pc_o, pred_taken_o, pred_target_o} !== {32'h100, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL midreset_hold got pc=%h pt=%b tgt=%h need pc=00000100 pt=0 tgt=00000000",
               pc_o, pred_taken_o, pred_target_o);
    end
    upd_valid_i = 1'b0;
    rst_n = 1'b1;
    m_reset();
    t = '{S(1, 32'h148, 0, 0, 0, 0, 0),
          S(1, 32'h108, 0, 0, 0, 0, 0),
          S(0, 0, 0, 0, 0, 0, 0)};
    foreach (t[k]) begin
      drive(t[k]);
      e = exp_q.pop_front();
      total++;
      if ({pc_o, pred_taken_o, pred_target_o} !== {e.pc, e.pt, e.ptg}) begin
        bad++;
        $display("FAIL midreset_after[%0d] got pc=%h pt=%b tgt=%h need pc=%h pt=%b tgt=%h",
                 k, pc_o, pred_taken_o, pred_target_o, e.pc, e.pt, e.ptg);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_alloc();
    test_saturation();
    test_priority();
    test_alias();
    test_wrap_same_cycle();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
